// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared state encoding and default sizes for the register file
package regfile_mp_pkg;
   typedef enum logic {INIT, RUN} state_t;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, reservation wins over a same-cycle clear
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int NWR   = 1,
   localparam int AW   = $clog2(NREGS)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   output logic [NREGS-1:0]  busy
);
   logic [NREGS-1:0] busy_d, busy_q;
   // clears first, then the reservation so it overrides; x0 is never busy
   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NWR; w++)
         if (clr_en[w]) busy_d[clr_addr[w*AW +: AW]] = 1'b0;
      if (rsv_en) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end
   // busy state register
   always_ff @(posedge clk)
      busy_q <= reset ? '0 : busy_d;
   assign busy = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with clear sweep, busy scoreboard and write bypass
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int NREGS  = DEF_NREGS,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                rsv_valid,
   input  logic [AW-1:0]       rsv_addr,
   output logic                init_done
);
   state_t           state_q;
   logic [AW-1:0]    idx_q;
   logic [XLEN-1:0]  mem_q [NREGS];
   logic [NWR-1:0]   wr_acc;
   logic [NREGS-1:0] busy;
   logic             rsv_en;

   assign init_done = state_q == RUN;
   assign rsv_en    = rsv_valid && init_done && rsv_addr != '0;

   // a write is accepted only after the sweep and never to x0
   always_comb begin
      wr_acc = '0;
      for (int w = 0; w < NWR; w++)
         wr_acc[w] = wr_en[w] && init_done && wr_addr[w*AW +: AW] != '0;
   end

   // clear sweep: one entry per cycle, then run forever until the next reset
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= INIT;
         idx_q   <= '0;
      end else if (state_q == INIT) begin
         idx_q <= idx_q + AW'(1);
         if (idx_q == AW'(NREGS - 1)) state_q <= RUN;
      end

   // storage without reset so it can become block RAM; higher port index wins
   always_ff @(posedge clk)
      if (!reset && state_q == INIT) mem_q[idx_q] <= '0;
      else
         for (int w = 0; w < NWR; w++)
            if (wr_acc[w]) mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];

   regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR)) u_sb (
      .clk(clk),
      .reset(reset),
      .rsv_en(rsv_en),
      .rsv_addr(rsv_addr),
      .clr_en(wr_acc),
      .clr_addr(wr_addr),
      .busy(busy)
   );

   // combinational reads; x0 and the sweep read 0, bypassed writes read as not busy
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < NRD; p++)
         if (init_done && rd_addr[p*AW +: AW] != '0) begin
            rd_data[p*XLEN +: XLEN] = mem_q[rd_addr[p*AW +: AW]];
            rd_busy[p] = busy[rd_addr[p*AW +: AW]];
            if (BYPASS != 0)
               for (int w = 0; w < NWR; w++)
                  if (wr_acc[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) begin
                     rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                     rd_busy[p] = 1'b0;
                  end
         end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: vector table, corner sequences and random traffic against a reference model
module tb_regfile_mp;
   localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

   logic                clk = 0, reset = 1;
   logic [NRD*AW-1:0]   rd_addr = '0;
   logic [NRD*XLEN-1:0] rd_data, rd_data_n;
   logic [NRD-1:0]      rd_busy, rd_busy_n;
   logic [NWR-1:0]      wr_en = '0;
   logic [NWR*AW-1:0]   wr_addr = '0;
   logic [NWR*XLEN-1:0] wr_data = '0;
   logic                rsv_valid = 0;
   logic [AW-1:0]       rsv_addr = '0;
   logic                init_done, init_done_n;

   int nchecks = 0, nerr = 0;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .init_done(init_done));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .init_done(init_done_n));

   // reference model: architectural registers, busy flags, cycles since reset release
   logic [XLEN-1:0] ref_mem [NREGS];
   bit              ref_busy [NREGS];
   bit              ref_done = 0;
   int              ref_cnt = 0;

   function automatic bit accepted(int w);
      return wr_en[w] && ref_done && wr_addr[w*AW +: AW] != 0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         ref_done = 0;
         ref_cnt  = 0;
         foreach (ref_busy[i]) ref_busy[i] = 0;
      end else if (!ref_done) begin
         ref_cnt++;
         if (ref_cnt == NREGS) begin
            ref_done = 1;
            foreach (ref_mem[i]) ref_mem[i] = 0;
         end
      end else begin
         for (int w = 0; w < NWR; w++)
            if (accepted(w)) begin
               ref_mem[wr_addr[w*AW +: AW]]  = wr_data[w*XLEN +: XLEN];
               ref_busy[wr_addr[w*AW +: AW]] = 0;
            end
         if (rsv_valid && rsv_addr != 0) ref_busy[rsv_addr] = 1;
      end
   end

   function automatic logic [XLEN-1:0] exp_data(logic [AW-1:0] a, bit byp);
      logic [XLEN-1:0] d;
      if (!ref_done || a == 0) return '0;
      d = ref_mem[a];
      if (byp)
         for (int w = 0; w < NWR; w++)
            if (accepted(w) && wr_addr[w*AW +: AW] == a) d = wr_data[w*XLEN +: XLEN];
      return d;
   endfunction

   function automatic logic exp_busy(logic [AW-1:0] a, bit byp);
      if (!ref_done || a == 0) return 1'b0;
      if (byp)
         for (int w = 0; w < NWR; w++)
            if (accepted(w) && wr_addr[w*AW +: AW] == a) return 1'b0;
      return ref_busy[a];
   endfunction

   task automatic chk(string name, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("init_done", 32'(init_done), 32'(ref_done));
      chk("init_done_nb", 32'(init_done_n), 32'(ref_done));
      for (int p = 0; p < NRD; p++) begin
         chk($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], exp_data(rd_addr[p*AW +: AW], 1));
         chk($sformatf("rd_busy[%0d]", p), 32'(rd_busy[p]), 32'(exp_busy(rd_addr[p*AW +: AW], 1)));
         chk($sformatf("rd_data_nb[%0d]", p), rd_data_n[p*XLEN +: XLEN], exp_data(rd_addr[p*AW +: AW], 0));
         chk($sformatf("rd_busy_nb[%0d]", p), 32'(rd_busy_n[p]), 32'(exp_busy(rd_addr[p*AW +: AW], 0)));
      end
   endtask

   task automatic drive(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1,
                        logic [31:0] wd1, logic rv, logic [4:0] ra, logic [4:0] r0, logic [4:0] r1);
      wr_en     = we;
      wr_addr   = {wa1, wa0};
      wr_data   = {wd1, wd0};
      rsv_valid = rv;
      rsv_addr  = ra;
      rd_addr   = {r1, r0};
   endtask

   task automatic idle();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   function automatic logic [4:0] raddr();
      return ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
   endfunction

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        rv;
      logic [4:0]  ra;
      logic [4:0]  rd;
      logic [31:0] e_d;
      logic        e_b;
      logic [31:0] n_d;
      logic        n_b;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
      tbl[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 32'h0,  1'b0, 32'h0,  1'b0};
      tbl[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 32'h0,  1'b0, 32'h0,  1'b0};
      tbl[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 32'h0,  1'b1, 32'h0,  1'b1};
      tbl[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 32'h0,  1'b1, 32'h0,  1'b1};
      tbl[6]  = '{2'b01, 5'd7, 32'h77,       5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 32'h77, 1'b0, 32'h0,  1'b1};
      tbl[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 32'h77, 1'b0, 32'h77, 1'b0};
      tbl[8]  = '{2'b01, 5'd7, 32'h78,       5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 32'h78, 1'b0, 32'h77, 1'b0};
      tbl[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 32'h78, 1'b1, 32'h78, 1'b1};
      tbl[10] = '{2'b11, 5'd9, 32'h11,       5'd9, 32'h22, 1'b0, 5'd0, 5'd9, 32'h22, 1'b0, 32'h0,  1'b0};
      tbl[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 32'h22, 1'b0, 32'h22, 1'b0};

      // one reset cycle, then the sweep must take exactly NREGS cycles
      idle();
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < NREGS; i++) begin
         drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(NREGS - 1 - i));
         #1;
         chk("init_done_low", 32'(init_done), 32'h0);
         chk("init_read0", rd_data[31:0], 32'h0);
         check_model();
         @(negedge clk);
      end
      for (int i = 0; i < NREGS; i += 2) begin
         drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(i + 1));
         #1;
         chk("init_done_high", 32'(init_done), 32'h1);
         chk("cleared_p0", rd_data[31:0], 32'h0);
         chk("cleared_p1", rd_data[63:32], 32'h0);
         check_model();
         @(negedge clk);
      end

      // table-driven vectors
      foreach (tbl[i]) begin
         drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1, tbl[i].rv, tbl[i].ra, tbl[i].rd, tbl[i].rd);
         #1;
         chk($sformatf("vec%0d_data", i), rd_data[31:0], tbl[i].e_d);
         chk($sformatf("vec%0d_busy", i), 32'(rd_busy[0]), 32'(tbl[i].e_b));
         chk($sformatf("vec%0d_data_nb", i), rd_data_n[31:0], tbl[i].n_d);
         chk($sformatf("vec%0d_busy_nb", i), 32'(rd_busy_n[0]), 32'(tbl[i].n_b));
         check_model();
         @(negedge clk);
      end

      // write x3 and reserve x4 in RUN, then reset mid-sweep and retry during INIT
      drive(2'b01, 5'd3, 32'hAA, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
      @(negedge clk);
      idle();
      rd_addr = {5'd4, 5'd3};
      #1;
      chk("x3_written", rd_data[31:0], 32'hAA);
      chk("x4_busy", 32'(rd_busy[1]), 32'h1);
      check_model();
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < NREGS; i++) begin
         drive(2'b11, 5'd3, 32'h55, 5'd4, 32'h66, 1'b1, 5'd5, 5'd3, 5'd4);
         #1;
         chk("resweep_low", 32'(init_done), 32'h0);
         chk("resweep_busy", 32'(rd_busy[0]), 32'h0);
         check_model();
         @(negedge clk);
      end
      idle();
      rd_addr = {5'd5, 5'd3};
      #1;
      chk("resweep_high", 32'(init_done), 32'h1);
      chk("x3_cleared", rd_data[31:0], 32'h0);
      chk("x5_not_busy", 32'(rd_busy[1]), 32'h0);
      check_model();
      @(negedge clk);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         drive(2'($urandom), raddr(), $urandom, raddr(), $urandom, 1'($urandom % 3 == 0), raddr(), raddr(), raddr());
         #1;
         check_model();
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two, >= 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 1, number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, 1 = forward same-cycle write data to reads.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 rd_addr  input  NRD*AW  read addresses, port p at bits [p*AW +: AW].
REQ-009 rd_data  output  NRD*XLEN  read data per port.
REQ-010 rd_busy  output  NRD  addressed register has a pending (reserved, unwritten) result.
REQ-011 wr_en  input  NWR  write enable per port.
REQ-012 wr_addr  input  NWR*AW  write destination per port.
REQ-013 wr_data  input  NWR*XLEN  write data per port.
REQ-014 rsv_valid  input  1  mark rsv_addr busy (instruction issue).
REQ-015 rsv_addr  input  AW  register to reserve.
REQ-016 init_done  output  1  high once the clear sweep has finished; writes and reservations are accepted only when high.

Function
REQ-017 Reads SHALL be combinational, zero latency; register 0 SHALL always read 0 and never be busy.
REQ-018 Write port w SHALL update register wr_addr[w] at the rising edge when wr_en[w]=1, init_done=1, and wr_addr[w] != 0.
REQ-019 On two enabled writes to the same address in one cycle, port 1 SHALL win.
REQ-020 With BYPASS=1, a read whose address matches an accepted write in the same cycle SHALL return that write's data (port 1 has priority), and rd_busy SHALL read 0 for it; with BYPASS=0, the read SHALL return the stored value.
REQ-021 Busy bit per register: an accepted write SHALL clear it; rsv_valid with init_done=1 and rsv_addr != 0 SHALL set it.
REQ-022 When a reservation and a write target the same register in the same cycle, the reservation SHALL win (bit ends set).
REQ-023 rd_busy[p] SHALL be the current busy bit of rd_addr[p], subject to REQ-020.
REQ-024 Clear FSM: states INIT and RUN; INIT writes 0 to entry idx each cycle and increments idx; when idx = NREGS-1 is written, the FSM SHALL go to RUN.
REQ-025 In INIT, all rd_data SHALL read 0, rd_busy SHALL be 0, and wr_en/rsv_valid SHALL be ignored.
REQ-026 init_done SHALL equal (state == RUN).
REQ-027 Storage SHALL have no per-entry reset, so it can map to block RAM; the clear sweep alone zeroes it.

Reset
REQ-028 While reset=1: state=INIT, idx=0, all busy bits=0, init_done=0.
REQ-029 The first clear write SHALL occur at the first rising edge with reset=0; init_done SHALL rise exactly NREGS cycles after reset deasserts.
REQ-030 Reset asserted mid-sweep or in RUN SHALL restart the sweep from idx 0.

Structure
REQ-031 A shared package SHALL hold the state enum (INIT, RUN) and default XLEN/NREGS constants used by the core.
REQ-032 One sub-module, regfile_scoreboard (busy bits, set/clear priority), is natural; storage, bypass and FSM stay in regfile_mp.

Verification
REQ-033 Reset 1 cycle, NREGS=32 -> init_done=0 for 32 cycles, then 1; every register reads 0.
REQ-034 Write x5=0xDEADBEEF; the same cycle reads x5 on port 0 -> BYPASS=1: 0xDEADBEEF the same cycle; BYPASS=0: 0 that cycle, 0xDEADBEEF the next cycle.
REQ-035 Write x0=0x1234 and reserve x0 -> reads of x0 return 0, rd_busy=0.
REQ-036 Reserve x7, then write x7 two cycles later -> rd_busy=1 for 2 cycles, then 0; same-cycle reserve and write of x7 -> busy stays 1.
REQ-037 NWR=2, both ports write x9 (0x11, 0x22) -> x9 reads 0x22.
REQ-038 Write x3=0xAA in RUN, then reset mid-sweep at idx=10 -> sweep restarts; init_done rises 32 cycles after the final deassertion; x3 reads 0; a write during INIT is ignored.
